// File: rtl/combination_lock.sv
// rtl/combination_lock.sv - four-digit keypad combination lock with multiplexed seven-segment display
//
// Purpose: accepts one 4-bit digit per cycle with enter high; four consecutive
// correct digits open the door until lock (or rst) re-secures it. Digits entered
// so far (or "OPEn" while unlocked) are scanned onto a 4-digit display.
//
// Ports:
//   clk                  system clock, rising-edge
//   rst                  synchronous active-high reset
//   x[3:0]               digit value, sampled when enter=1
//   enter                digit strobe, one digit per high cycle
//   lock                 re-lock / clear request (priority over enter)
//   door_open            1 while unlocked (registered)
//   seven_segment_data   active-low segments, bit0=a .. bit6=g, bit7=dp (always 1)
//   seven_segment_enable active-low one-hot digit select, bit0 = rightmost
module combination_lock #(
  parameter logic [3:0] CODE0    = 4'd1,
  parameter logic [3:0] CODE1    = 4'd2,
  parameter logic [3:0] CODE2    = 4'd3,
  parameter logic [3:0] CODE3    = 4'd4,
  parameter int         SCAN_DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] x,
  input  logic       enter,
  input  logic       lock,
  output logic       door_open,
  output logic [7:0] seven_segment_data,
  output logic [3:0] seven_segment_enable
);

  typedef enum logic [2:0] {S0, S1, S2, S3, OPEN} state_t;

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  state_t      state, state_next;
  logic [15:0] digits, digits_next;   // slot 0 (bits 3:0) holds the newest digit
  logic [1:0]  count, count_next;
  logic [3:0]  expected;
  logic [CW-1:0] scan_cnt;
  logic [1:0]  scan_idx;
  logic [6:0]  glyph;

  function automatic logic [6:0] hex7(input logic [3:0] d);
    case (d)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S0;
      digits    <= '0;
      count     <= '0;
      door_open <= 1'b0;
    end else begin
      state     <= state_next;
      digits    <= digits_next;
      count     <= count_next;
      door_open <= (state_next == OPEN);
    end
  end

  always_comb begin
    state_next  = state;
    digits_next = digits;
    count_next  = count;
    case (state)
      S0:      expected = CODE0;
      S1:      expected = CODE1;
      S2:      expected = CODE2;
      default: expected = CODE3;
    endcase

    if (lock) begin
      state_next  = S0;
      digits_next = '0;
      count_next  = '0;
    end else if (enter && state != OPEN) begin
      if (x == expected) begin
        case (state)
          S0:      state_next = S1;
          S1:      state_next = S2;
          S2:      state_next = S3;
          default: state_next = OPEN;
        endcase
        if (state == S3) begin
          digits_next = '0;
          count_next  = '0;
        end else begin
          digits_next = {digits[11:0], x};
          count_next  = count + 2'd1;
        end
      end else if (x == CODE0) begin
        // A wrong digit that is itself the first code digit restarts the sequence.
        state_next  = S1;
        digits_next = {12'd0, x};
        count_next  = 2'd1;
      end else begin
        state_next  = S0;
        digits_next = '0;
        count_next  = '0;
      end
    end
  end

  always_comb begin
    glyph = 7'h7F;
    if (state == OPEN) begin
      case (scan_idx)
        2'd3:    glyph = 7'b1000000;
        2'd2:    glyph = 7'b0001100;
        2'd1:    glyph = 7'b0000110;
        default: glyph = 7'b0101011;
      endcase
    end else if (scan_idx < count) begin
      glyph = hex7(digits[scan_idx*4 +: 4]);
    end
  end

  // Segment data and digit enable are both registered from the same scan index
  // so they always change on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt             <= '0;
      scan_idx             <= '0;
      seven_segment_enable <= 4'b1110;
      seven_segment_data   <= 8'hFF;
    end else begin
      if (scan_cnt == CW'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        scan_idx <= scan_idx + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      seven_segment_enable <= ~(4'b0001 << scan_idx);
      seven_segment_data   <= {1'b1, glyph};
    end
  end

endmodule

// File: tb/tb_combination_lock.sv
// tb/tb_combination_lock.sv - directed self-checking bench for combination_lock
module tb_combination_lock;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] x;
  logic       enter;
  logic       lock;
  logic       door_open;
  logic [7:0] seven_segment_data;
  logic [3:0] seven_segment_enable;

  int vectors = 0;
  int errors  = 0;

  combination_lock dut (
    .clk(clk),
    .rst(rst),
    .x(x),
    .enter(enter),
    .lock(lock),
    .door_open(door_open),
    .seven_segment_data(seven_segment_data),
    .seven_segment_enable(seven_segment_enable)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic digit(input logic [3:0] d, input logic exp_door, input string tag);
    x = d; enter = 1'b1; lock = 1'b0;
    step();
    chk(tag, {7'd0, door_open}, {7'd0, exp_door});
  endtask

  // Wait (bounded) until the given digit position is selected, then check its segments.
  task automatic show(input int pos, input logic [7:0] exp, input string tag);
    int n = 0;
    logic [3:0] target;
    target = ~(4'b0001 << pos);
    while (seven_segment_enable !== target && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) chk({tag, "_timeout"}, {4'd0, seven_segment_enable}, {4'd0, target});
    else chk(tag, seven_segment_data, exp);
  endtask

  task automatic wait_en(input logic [3:0] target);
    int n = 0;
    while (seven_segment_enable !== target && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) chk("scan_wait_timeout", {4'd0, seven_segment_enable}, {4'd0, target});
  endtask

  initial begin
    logic [3:0] en_seq [4];
    logic [3:0] prev;
    int n;
    en_seq[0] = 4'b1101; en_seq[1] = 4'b1011; en_seq[2] = 4'b0111; en_seq[3] = 4'b1110;

    rst = 1'b1; x = 4'd0; enter = 1'b0; lock = 1'b0;
    step(); step();
    chk("rst_door", {7'd0, door_open}, 8'd0);
    chk("rst_en", {4'd0, seven_segment_enable}, 8'h0E);
    chk("rst_data", seven_segment_data, 8'hFF);
    rst = 1'b0;

    // Basic open
    digit(4'd1, 1'b0, "open_d1");
    digit(4'd2, 1'b0, "open_d2");
    digit(4'd3, 1'b0, "open_d3");
    digit(4'd4, 1'b1, "open_d4");
    enter = 1'b0;
    show(3, 8'hC0, "disp_O");
    show(2, 8'h8C, "disp_P");
    show(1, 8'h86, "disp_E");
    show(0, 8'hAB, "disp_n");

    // enter ignored while open
    x = 4'd6; enter = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("open_idle", {7'd0, door_open}, 8'd1);
    end
    digit(4'd6, 1'b1, "open_ign6");
    digit(4'd1, 1'b1, "open_ign1");
    digit(4'd2, 1'b1, "open_ign2");
    digit(4'd2, 1'b1, "open_ign2b");
    digit(4'd2, 1'b1, "open_ign2c");
    enter = 1'b0;
    show(0, 8'hAB, "open_keep_n");
    show(3, 8'hC0, "open_keep_O");

    // lock beats enter; then a non-CODE0 mismatch stays in S0
    x = 4'd2; enter = 1'b1; lock = 1'b1;
    step();
    chk("lock_door", {7'd0, door_open}, 8'd0);
    digit(4'd2, 1'b0, "mismatch_door");
    enter = 1'b0;
    show(0, 8'hFF, "lock_blank0");
    show(3, 8'hFF, "lock_blank3");

    // 1,2,3,1,2,3,4 with enter held high
    digit(4'd1, 1'b0, "ov_1");
    digit(4'd2, 1'b0, "ov_2");
    digit(4'd3, 1'b0, "ov_3");
    digit(4'd1, 1'b0, "ov_1b");
    digit(4'd2, 1'b0, "ov_2b");
    digit(4'd3, 1'b0, "ov_3b");
    digit(4'd4, 1'b1, "ov_4");
    enter = 1'b0; lock = 1'b1;
    step();
    chk("relock_door", {7'd0, door_open}, 8'd0);
    lock = 1'b0;

    // Partial entry display, then lock clears it
    digit(4'd1, 1'b0, "part_1");
    digit(4'd2, 1'b0, "part_2");
    enter = 1'b0;
    show(0, 8'hA4, "part_slot0");
    show(1, 8'hF9, "part_slot1");
    show(2, 8'hFF, "part_slot2");
    lock = 1'b1;
    step();
    lock = 1'b0;
    show(0, 8'hFF, "clr_slot0");
    show(1, 8'hFF, "clr_slot1");

    // 1,2,3 then 1 restarts at S1 with buffer {1}
    digit(4'd1, 1'b0, "rs_1");
    digit(4'd2, 1'b0, "rs_2");
    digit(4'd3, 1'b0, "rs_3");
    digit(4'd1, 1'b0, "rs_1b");
    enter = 1'b0;
    show(0, 8'hF9, "rs_slot0");
    show(1, 8'hFF, "rs_slot1");
    digit(4'd2, 1'b0, "rs_2b");
    digit(4'd3, 1'b0, "rs_3b");
    digit(4'd4, 1'b1, "rs_4");
    enter = 1'b0;

    // Scan timing: align on a 0111 -> 1110 transition, then time each step
    wait_en(4'b0111);
    wait_en(4'b1110);
    for (int k = 0; k < 4; k++) begin
      prev = seven_segment_enable;
      n = 0;
      while (seven_segment_enable === prev && n < 40) begin
        step();
        n++;
      end
      chk("scan_period", n[7:0], 8'd16);
      chk("scan_en", {4'd0, seven_segment_enable}, {4'd0, en_seq[k]});
    end

    // Reset while open
    rst = 1'b1;
    step();
    chk("rst2_door", {7'd0, door_open}, 8'd0);
    chk("rst2_en", {4'd0, seven_segment_enable}, 8'h0E);
    chk("rst2_data", seven_segment_data, 8'hFF);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
